bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
- Sits directly upstream of the 8-digit seven-segment scan/decoder stage and drives its 32-bit display word.
- Lets counters and arithmetic results appear as decimal (8 BCD digits) instead of hex on the eight-digit display.
- Out-of-range inputs produce an all-F display word plus an overflow flag.

Parameters:
- IN_W, 27, width of the binary input; legal range 1..32. 27 is the minimum width that covers 99,999,999.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  conversion request; sampled only when busy=0.
- bin_in  in  IN_W  unsigned binary value; captured on the edge that accepts start.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse; bcd_out and ovf are valid and updated.
- ovf  out  1  captured value exceeded 99,999,999; held until next done.
- bcd_out  out  32  result: [3:0]=units digit … [31:28]=ten-millions digit. Held between conversions; connects directly to the display stage's 32-bit input.

Behaviour:
- Reset (synchronous, active-high):
  - busy=0, done=0, ovf=0, bcd_out=32'h0000_0000; FSM goes to IDLE.
  - Reset during a conversion aborts it with no done pulse and no partial result.
  - reset has priority over start.
- FSM states: IDLE, SHIFT.
  - IDLE: busy=0.
    - start=1 at edge k: latch bin_in into shift register sh, clear the 32-bit BCD accumulator acc, set count=0, go to SHIFT.
    - Also at edge k: compute ovf_pend = (zero-extended bin_in > 99_999_999) and store it internally.
  - SHIFT: busy=1. Each edge does, in this order:
    - For each of the 8 nibbles of acc, add 3 if the nibble is ≥5 (all in parallel, combinational).
    - Shift {acc, sh} left by 1; the MSB of sh enters acc[0].
    - Increment count.
    - On the edge where count reaches IN_W-1 (the IN_W-th shift): load bcd_out from the post-shift acc, or 32'hFFFF_FFFF if ovf_pend; ovf<=ovf_pend; done<=1; go to IDLE.
- Timing:
  - Latency: start sampled at edge k → done high in the cycle after edge k+IN_W, i.e. exactly IN_W edges later.
  - busy is high during the cycles after edges k..k+IN_W-1 and low in the done cycle.
  - done lasts exactly one cycle and clears at the next edge unless a new conversion completes there.
- start handling:
  - start while busy=1 is ignored; no queuing, and bin_in is not re-captured.
  - start during the done cycle (busy=0) is accepted; on the next edge busy=1 and done=0.
  - start held high continuously gives back-to-back conversions, one every IN_W+1 cycles.
- Output stability:
  - bcd_out and ovf change only on the done edge (and on reset).
  - No intermediate accumulator values are ever visible on bcd_out, so the display never flickers mid-conversion.
- Width rules:
  - acc is 32 bits; the add-3 carry stays within each nibble because the nibble is ≤9 before the shift.
  - With IN_W<27 overflow cannot occur and ovf stays 0.
  - With IN_W=32 the comparison is done in 32 bits.
- bin_in changing after capture has no effect on the running conversion.

Test Plan:
- IN_W=27, bin_in=0, start pulse at edge k → done at cycle k+27, bcd_out=32'h0000_0000, ovf=0; busy high for exactly 27 cycles.
- bin_in=12_345_678 → bcd_out=32'h1234_5678, ovf=0. bin_in=99_999_999 → bcd_out=32'h9999_9999, ovf=0. bin_in=5 → 32'h0000_0005 (exercises the add-3 boundary).
- bin_in=100_000_000 → bcd_out=32'hFFFF_FFFF, ovf=1. A following conversion of 42 → bcd_out=32'h0000_0042, ovf=0.
- start pulsed again at cycle k+10 with a different bin_in → ignored; result is that of the first value, and only one done pulse occurs.
- start held high, bin_in=7 then 8 → done pulses 28 cycles apart; bcd_out goes 7 then 8; bcd_out stable between the pulses.
- Complete a conversion of 1234 (bcd_out=32'h0000_1234), start a new one, then assert reset at cycle k+12 → next cycle busy=0, done=0, ovf=0, bcd_out=0, and no done pulse follows; a fresh start converts correctly.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// Feeds the 8-digit seven-segment display stage with a 32-bit packed BCD word.
// Values above 99,999,999 give an all-F display word and raise ovf.
//
// Ports:
//   clk     - system clock, rising edge
//   reset   - synchronous, active-high reset (priority over start)
//   start   - conversion request, sampled only while busy=0
//   bin_in  - unsigned binary value, captured on the edge that accepts start
//   busy    - high while a conversion is running
//   done    - one-cycle pulse when bcd_out/ovf have been updated
//   ovf     - last converted value exceeded 99,999,999
//   bcd_out - result, [3:0] units ... [31:28] ten-millions; held between conversions
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// SHIFT | one add-3/shift step per clock, IN_W steps total

module bin2bcd_seq #(
    parameter int IN_W = 27
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [IN_W-1:0] bin_in,
    output logic            busy,
    output logic            done,
    output logic            ovf,
    output logic [31:0]     bcd_out
);

    localparam int          CNT_W   = $clog2(IN_W + 1);
    localparam logic [31:0] MAX_DEC = 32'd99_999_999;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state;
    logic [IN_W-1:0]   sh;
    logic [31:0]       acc;
    logic [31:0]       acc_adj;
    logic [31:0]       acc_next;
    logic [CNT_W-1:0]  count;
    logic              ovf_pend;
    logic [31:0]       bin_ext;
    logic              last;

    // Each nibble is at most 9 before the shift, so +3 never carries out of it.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 8; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
        acc_next = {acc_adj[30:0], sh[IN_W-1]};
        bin_ext  = 32'(bin_in);
        last     = (count == CNT_W'(IN_W - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            bcd_out  <= 32'h0000_0000;
            sh       <= '0;
            acc      <= 32'h0000_0000;
            count    <= '0;
            ovf_pend <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sh       <= bin_in;
                        acc      <= 32'h0000_0000;
                        count    <= '0;
                        ovf_pend <= (bin_ext > MAX_DEC);
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc   <= acc_next;
                    sh    <= sh << 1;
                    count <= count + CNT_W'(1);
                    // Only the finished accumulator ever reaches bcd_out.
                    if (last) begin
                        bcd_out <= ovf_pend ? 32'hFFFF_FFFF : acc_next;
                        ovf     <= ovf_pend;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

    localparam int IN_W = 27;
    localparam int LIMIT = 100;

    logic            clk;
    logic            reset;
    logic            start;
    logic [IN_W-1:0] bin_in;
    logic            busy;
    logic            done;
    logic            ovf;
    logic [31:0]     bcd_out;

    int tests_run;
    int tests_failed;

    // {ovf, bcd} expected results, pushed at start, popped at done
    logic [32:0] exp_q[$];

    bin2bcd_seq #(.IN_W(IN_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf),
        .bcd_out (bcd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32:0] model(input longint unsigned v);
        logic [32:0] r;
        longint unsigned t;
        r = '0;
        t = v;
        if (v > 64'd99_999_999) begin
            r = {1'b1, 32'hFFFF_FFFF};
        end else begin
            for (int i = 0; i < 8; i++) begin
                r[4*i +: 4] = 4'(t % 10);
                t = t / 10;
            end
        end
        return r;
    endfunction

    // advance one edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drive start for exactly one accepting edge; returns just after edge k
    task automatic pulse_start(input logic [IN_W-1:0] v, input bit push);
        bin_in = v;
        start  = 1'b1;
        if (push) exp_q.push_back(model(64'(v)));
        tick();
        start  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        bin_in = IN_W'(12345);
        tick(); tick(); tick();
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", done); end
        tests_run++;
        if (ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf got %b want 0", ovf); end
        tests_run++;
        if (bcd_out !== 32'h0) begin tests_failed++; $display("FAIL reset_bcd got %h want 00000000", bcd_out); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_value(input logic [IN_W-1:0] v);
        int lat;
        int nbusy;
        logic [32:0] e;
        pulse_start(v, 1'b1);
        lat = 0;
        nbusy = 0;
        while (done !== 1'b1 && lat < LIMIT) begin
            if (busy === 1'b1) nbusy++;
            tick();
            lat++;
        end
        e = exp_q.pop_front();
        tests_run++;
        if (lat !== IN_W) begin tests_failed++; $display("FAIL latency v=%0d got %0d want %0d", v, lat, IN_W); end
        tests_run++;
        if (nbusy !== IN_W) begin tests_failed++; $display("FAIL busy_cycles v=%0d got %0d want %0d", v, nbusy, IN_W); end
        tests_run++;
        if (bcd_out !== e[31:0]) begin tests_failed++; $display("FAIL bcd v=%0d got %h want %h", v, bcd_out, e[31:0]); end
        tests_run++;
        if (ovf !== e[32]) begin tests_failed++; $display("FAIL ovf v=%0d got %b want %b", v, ovf, e[32]); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL busy_at_done v=%0d got %b want 0", v, busy); end
        tick();
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL done_width v=%0d got %b want 0", v, done); end
    endtask

    task automatic test_ignored_start();
        int lat;
        int ndone;
        logic [31:0] got;
        logic [32:0] e;
        pulse_start(IN_W'(1111), 1'b1);
        lat = 0;
        ndone = 0;
        got = 32'hDEAD_BEEF;
        while (lat < 60) begin
            if (lat == 10) begin
                bin_in = IN_W'(2222);
                start  = 1'b1;
            end else begin
                start  = 1'b0;
            end
            if (done === 1'b1) begin
                ndone++;
                got = bcd_out;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        e = exp_q.pop_front();
        tests_run++;
        if (ndone !== 1) begin tests_failed++; $display("FAIL ignored_done_count got %0d want 1", ndone); end
        tests_run++;
        if (got !== e[31:0]) begin tests_failed++; $display("FAIL ignored_bcd got %h want %h", got, e[31:0]); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int l1;
        int l2;
        bit stable;
        logic [31:0] held;
        logic [32:0] e;
        bin_in = IN_W'(7);
        start  = 1'b1;
        exp_q.push_back(model(64'd7));
        tick();
        bin_in = IN_W'(8);
        exp_q.push_back(model(64'd8));
        lat = 0;
        l1 = -1;
        l2 = -1;
        stable = 1'b1;
        held = '0;
        while (l2 < 0 && lat < LIMIT) begin
            if (done === 1'b1) begin
                e = exp_q.pop_front();
                tests_run++;
                if (bcd_out !== e[31:0]) begin tests_failed++; $display("FAIL b2b_bcd got %h want %h", bcd_out, e[31:0]); end
                if (l1 < 0) begin
                    l1 = lat;
                    held = bcd_out;
                end else begin
                    l2 = lat;
                    start = 1'b0;
                end
            end else if (l1 >= 0 && bcd_out !== held) begin
                stable = 1'b0;
            end
            if (l2 < 0) begin
                tick();
                lat++;
            end
        end
        start = 1'b0;
        tests_run++;
        if (l2 - l1 !== IN_W + 1) begin tests_failed++; $display("FAIL b2b_spacing got %0d want %0d (l1=%0d l2=%0d)", l2 - l1, IN_W + 1, l1, l2); end
        tests_run++;
        if (stable !== 1'b1) begin tests_failed++; $display("FAIL b2b_stable got %b want 1", stable); end
        while (exp_q.size() > 0) void'(exp_q.pop_front());
        tick(); tick();
    endtask

    task automatic test_reset_abort();
        int lat;
        int ndone;
        test_value(IN_W'(1234));
        pulse_start(IN_W'(5678), 1'b0);
        lat = 0;
        while (lat < 12) begin
            tick();
            lat++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy got %b want 0", busy); end
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL abort_done got %b want 0", done); end
        tests_run++;
        if (ovf !== 1'b0) begin tests_failed++; $display("FAIL abort_ovf got %b want 0", ovf); end
        tests_run++;
        if (bcd_out !== 32'h0) begin tests_failed++; $display("FAIL abort_bcd got %h want 00000000", bcd_out); end
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) ndone++;
            tick();
        end
        tests_run++;
        if (ndone !== 0) begin tests_failed++; $display("FAIL abort_no_done got %0d want 0", ndone); end
        test_value(IN_W'(5678));
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b0;
        start = 1'b0;
        bin_in = '0;
        test_reset();
        test_value(IN_W'(0));
        test_value(IN_W'(12_345_678));
        test_value(IN_W'(99_999_999));
        test_value(IN_W'(5));
        test_value(IN_W'(100_000_000));
        test_value(IN_W'(42));
        test_value(IN_W'(134_217_727));
        test_value(IN_W'(90_909_090));
        test_ignored_start();
        test_back_to_back();
        test_reset_abort();
        tests_run++;
        if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL scoreboard_empty got %0d want 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
